// File: rtl/cmd_reset_seq_if.sv
// Command/status bundle between a controller and the reset sequencer.
interface cmd_reset_seq_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned SEQ_W = 8
);
    logic             start;
    logic             abort;
    logic             repeat_en;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] run_len;
    logic [N_CH-1:0]  ch_reset;
    logic             busy;
    logic             done;
    logic [SEQ_W-1:0] seq_count;

    modport master (output start, abort, repeat_en, delay, width, run_len,
                    input  ch_reset, busy, done, seq_count);
    modport slave  (input  start, abort, repeat_en, delay, width, run_len,
                    output ch_reset, busy, done, seq_count);
endinterface

// File: rtl/cmd_reset_seq.sv
// Programmable reset sequencer: delay, staggered per-channel reset pulses,
// run window, completion pulse; optionally repeats with the latched config.
module cmd_reset_seq #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned STAGGER = 2,
    parameter int unsigned SEQ_W   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    cmd_reset_seq_if.slave bus
);
    localparam int unsigned SPAN = (N_CH - 1) * STAGGER;
    localparam int unsigned PW   = CNT_W + $clog2(SPAN + 2);
    localparam int unsigned PW1  = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_DELAY, S_PULSE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PW-1:0]    pcnt, pcnt_nxt;
    logic [CNT_W-1:0] cfg_delay, cfg_delay_nxt;
    logic [CNT_W-1:0] cfg_width, cfg_width_nxt;
    logic [CNT_W-1:0] cfg_run, cfg_run_nxt;
    logic             cfg_rep, cfg_rep_nxt;
    logic [N_CH-1:0]  ch_reset_q, ch_reset_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [SEQ_W-1:0] seq_q, seq_nxt;
    logic [PW-1:0]    p_last;
    logic [PW:0]      rel;

    // Next state plus output decode from the next state, so the registered
    // outputs line up with the state they describe.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pcnt_nxt      = pcnt;
        cfg_delay_nxt = cfg_delay;
        cfg_width_nxt = cfg_width;
        cfg_run_nxt   = cfg_run;
        cfg_rep_nxt   = cfg_rep;
        ch_reset_nxt  = '0;
        rel           = '0;
        p_last        = PW'(cfg_width) + PW'(SPAN) - PW'(1);

        case (state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    cfg_delay_nxt = bus.delay;
                    cfg_width_nxt = (bus.width == '0) ? CNT_W'(1) : bus.width;
                    cfg_run_nxt   = bus.run_len;
                    cfg_rep_nxt   = bus.repeat_en;
                    cnt_nxt       = '0;
                    pcnt_nxt      = '0;
                    state_nxt     = (bus.delay == '0) ? S_PULSE : S_DELAY;
                end
            end
            S_DELAY: begin
                if (cnt == cfg_delay - CNT_W'(1)) begin
                    pcnt_nxt  = '0;
                    state_nxt = S_PULSE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (pcnt == p_last) begin
                    cnt_nxt   = '0;
                    state_nxt = (cfg_run == '0) ? S_DONE : S_RUN;
                end else begin
                    pcnt_nxt = pcnt + PW'(1);
                end
            end
            S_RUN: begin
                if (cnt == cfg_run - CNT_W'(1)) state_nxt = S_DONE;
                else                            cnt_nxt   = cnt + CNT_W'(1);
            end
            S_DONE: begin
                cnt_nxt  = '0;
                pcnt_nxt = '0;
                if (!cfg_rep)              state_nxt = S_IDLE;
                else if (cfg_delay == '0)  state_nxt = S_PULSE;
                else                       state_nxt = S_DELAY;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (bus.abort) state_nxt = S_IDLE;

        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
        seq_nxt  = seq_q + SEQ_W'(done_nxt);

        // Channel k is high while pcnt sits in [k*STAGGER, k*STAGGER+W).
        if (state_nxt == S_PULSE) begin
            for (int k = 0; k < N_CH; k++) begin
                rel = {1'b0, pcnt_nxt} - PW1'(k * STAGGER);
                ch_reset_nxt[k] = !rel[PW] && (rel[PW-1:0] < PW'(cfg_width_nxt));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pcnt       <= '0;
            cfg_delay  <= '0;
            cfg_width  <= '0;
            cfg_run    <= '0;
            cfg_rep    <= 1'b0;
            ch_reset_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seq_q      <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pcnt       <= pcnt_nxt;
            cfg_delay  <= cfg_delay_nxt;
            cfg_width  <= cfg_width_nxt;
            cfg_run    <= cfg_run_nxt;
            cfg_rep    <= cfg_rep_nxt;
            ch_reset_q <= ch_reset_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            seq_q      <= seq_nxt;
        end
    end

    assign bus.ch_reset  = ch_reset_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.seq_count = seq_q;
endmodule

// File: tb/tb_cmd_reset_seq.sv
// Self-checking bench for cmd_reset_seq against a timeline-formula model.
module tb_cmd_reset_seq;
    localparam int N_CH    = 4;
    localparam int CNT_W   = 16;
    localparam int STAGGER = 2;
    localparam int SEQ_W   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [SEQ_W-1:0] exp_seq = '0;
    logic [N_CH+1:0]  got, exp_v;

    cmd_reset_seq_if #(.N_CH(N_CH), .CNT_W(CNT_W), .SEQ_W(SEQ_W)) bus ();

    cmd_reset_seq #(.N_CH(N_CH), .CNT_W(CNT_W), .STAGGER(STAGGER), .SEQ_W(SEQ_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {ch_reset, busy, done} for cycle c after the start edge (c=1 is the
    // cycle right after it). A sequence spans L = D + P + R + 1 cycles.
    function automatic logic [N_CH+1:0] exp_out(int c, int d, int w, int r, bit rep);
        int weff, p, l, j, cl;
        logic [N_CH+1:0] v;
        v    = '0;
        weff = (w == 0) ? 1 : w;
        p    = weff + (N_CH - 1) * STAGGER;
        l    = d + p + r + 1;
        if (c < 1) return v;
        j = (c - 1) / l;
        if (!rep && j > 0) return v;
        cl   = c - j * l;
        v[1] = 1'b1;
        v[0] = (cl == l);
        for (int k = 0; k < N_CH; k++)
            if (cl >= 1 + d + k * STAGGER && cl <= d + k * STAGGER + weff) v[2+k] = 1'b1;
        return v;
    endfunction

    function automatic int seq_len(int d, int w, int r);
        return d + ((w == 0) ? 1 : w) + (N_CH - 1) * STAGGER + r + 1;
    endfunction

    task automatic set_idle();
        bus.start = 1'b0; bus.abort = 1'b0; bus.repeat_en = 1'b0;
        bus.delay = '0;   bus.width = '0;   bus.run_len = '0;
    endtask

    // Junk on start/config while the sequencer is busy; it must all be ignored.
    task automatic scramble();
        bus.start     = 1'($urandom_range(0, 1));
        bus.repeat_en = 1'($urandom_range(0, 1));
        bus.delay     = CNT_W'($urandom_range(0, 9));
        bus.width     = CNT_W'($urandom_range(0, 9));
        bus.run_len   = CNT_W'($urandom_range(0, 9));
    endtask

    task automatic drive_start(int d, int w, int r, bit rep);
        bus.start = 1'b1; bus.repeat_en = rep;
        bus.delay = CNT_W'(d); bus.width = CNT_W'(w); bus.run_len = CNT_W'(r);
        @(posedge clk); #1;
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_seq = '0;
        n_tests++;
        if ({bus.ch_reset, bus.busy, bus.done} !== '0 || bus.seq_count !== exp_seq) begin
            n_fail++;
            $display("FAIL reset_hold got=%b/%0d exp=0/0", {bus.ch_reset, bus.busy, bus.done}, bus.seq_count);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({bus.ch_reset, bus.busy, bus.done} !== '0 || bus.seq_count !== exp_seq) begin
                n_fail++;
                $display("FAIL reset_idle i=%0d got=%b/%0d exp=0/0", i, {bus.ch_reset, bus.busy, bus.done}, bus.seq_count);
            end
        end
    endtask

    // One non-repeating sequence with busy-time junk, checked every cycle.
    task automatic run_single(string name, int d, int w, int r);
        int l;
        l = seq_len(d, w, r);
        drive_start(d, w, r, 1'b0);
        for (int c = 1; c <= l + 3; c++) begin
            got   = {bus.ch_reset, bus.busy, bus.done};
            exp_v = exp_out(c, d, w, r, 1'b0);
            if (exp_v[0]) exp_seq = exp_seq + SEQ_W'(1);
            n_tests++;
            if (got !== exp_v || bus.seq_count !== exp_seq) begin
                n_fail++;
                $display("FAIL %s d=%0d w=%0d r=%0d c=%0d got=%b/%0d exp=%b/%0d",
                         name, d, w, r, c, got, bus.seq_count, exp_v, exp_seq);
            end
            if (c <= l) scramble(); else set_idle();
            @(posedge clk); #1;
        end
        set_idle();
    endtask

    task automatic test_single();   run_single("single", 3, 2, 5); endtask
    task automatic test_corners();  run_single("corners", 0, 0, 0); endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++)
            run_single("random", int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 5)));
    endtask

    // Repeating sequence aborted at cycle abort_c; everything after must be idle.
    task automatic run_abort(string name, int d, int w, int r, int abort_c);
        drive_start(d, w, r, 1'b1);
        for (int c = 1; c <= abort_c + 3; c++) begin
            got   = {bus.ch_reset, bus.busy, bus.done};
            exp_v = (c <= abort_c) ? exp_out(c, d, w, r, 1'b1) : '0;
            if (exp_v[0]) exp_seq = exp_seq + SEQ_W'(1);
            n_tests++;
            if (got !== exp_v || bus.seq_count !== exp_seq) begin
                n_fail++;
                $display("FAIL %s c=%0d abort_c=%0d got=%b/%0d exp=%b/%0d",
                         name, c, abort_c, got, bus.seq_count, exp_v, exp_seq);
            end
            if (c < abort_c) scramble(); else set_idle();
            bus.abort = (c == abort_c);
            @(posedge clk); #1;
        end
        set_idle();
    endtask

    task automatic test_repeat_abort();
        int l, s0;
        s0 = int'(exp_seq);
        l  = seq_len(2, 1, 3);
        run_abort("repeat_abort", 2, 1, 3, 3 * l + 2 + 7 + 2);
        n_tests++;
        if (bus.seq_count !== SEQ_W'(s0 + 3)) begin
            n_fail++;
            $display("FAIL repeat_count got=%0d exp=%0d", bus.seq_count, SEQ_W'(s0 + 3));
        end
    endtask

    task automatic test_abort_done();
        int d, w, r;
        d = int'($urandom_range(0, 3)); w = int'($urandom_range(0, 3)); r = int'($urandom_range(0, 3));
        run_abort("abort_done", d, w, r, seq_len(d, w, r));
    endtask

    task automatic test_abort_start();
        bus.start = 1'b1; bus.abort = 1'b1; bus.delay = CNT_W'(0); bus.width = CNT_W'(3);
        @(posedge clk); #1;
        set_idle();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({bus.ch_reset, bus.busy, bus.done} !== '0 || bus.seq_count !== exp_seq) begin
                n_fail++;
                $display("FAIL abort_start i=%0d got=%b/%0d exp=0/%0d", i,
                         {bus.ch_reset, bus.busy, bus.done}, bus.seq_count, exp_seq);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        drive_start(1, 4, 2, 1'b0);
        for (int c = 1; c < 5; c++) begin @(posedge clk); #1; end
        exp_v = exp_out(5, 1, 4, 2, 1'b0);
        got   = {bus.ch_reset, bus.busy, bus.done};
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL async_pre got=%b exp=%b", got, exp_v);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_seq = '0;
        n_tests++;
        if ({bus.ch_reset, bus.busy, bus.done} !== '0 || bus.seq_count !== exp_seq) begin
            n_fail++;
            $display("FAIL async_reset got=%b/%0d exp=0/0", {bus.ch_reset, bus.busy, bus.done}, bus.seq_count);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({bus.ch_reset, bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL async_after got=%b exp=0", {bus.ch_reset, bus.busy, bus.done});
        end
    endtask

    task automatic test_wrap();
        int want [5];
        want = '{1, 2, 3, 0, 1};
        for (int n = 0; n < 5; n++) begin
            run_single("wrap_run", 0, 0, 0);
            n_tests++;
            if (bus.seq_count !== SEQ_W'(want[n])) begin
                n_fail++;
                $display("FAIL wrap n=%0d got=%0d exp=%0d", n, bus.seq_count, want[n]);
            end
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_single();
        test_corners();
        test_random();
        test_repeat_abort();
        test_abort_done();
        test_abort_start();
        test_async_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
